// File: rtl/exc_check_arbiter_if.sv
// Request/result and checker handshake bundle for exc_check_arbiter.
// master: arbiter side; slave: requesters plus checker side.
interface exc_check_arbiter_if #(
    parameter int NREQ = 3
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]      REQ;
    logic [32*NREQ-1:0]   REQ_DATA;
    logic [NREQ-1:0]      GNT;
    logic                 RES_VALID;
    logic [2:0]           RES_EXC;
    logic [IW-1:0]        RES_ID;
    logic [31:0]          CHK_DATA;
    logic                 CHK_VALID;
    logic                 CHK_ACK;
    logic [2:0]           CHK_EXC;
    logic                 ERR_TIMEOUT;

    modport master (
        input  REQ, REQ_DATA, CHK_ACK, CHK_EXC,
        output GNT, RES_VALID, RES_EXC, RES_ID,
        output CHK_DATA, CHK_VALID, ERR_TIMEOUT
    );

    modport slave (
        output REQ, REQ_DATA, CHK_ACK, CHK_EXC,
        input  GNT, RES_VALID, RES_EXC, RES_ID,
        input  CHK_DATA, CHK_VALID, ERR_TIMEOUT
    );
endinterface

// File: rtl/exc_check_arbiter.sv
// Round-robin sharing of one exception checker between NREQ requesters.
// Registered outputs, three-state FSM, optional watchdog on the checker ACK.
module exc_check_arbiter #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 15
) (
    input  logic               CLK,
    input  logic               RSTN,
    exc_check_arbiter_if.master bus
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   ptr, ptr_n;
    logic [IW-1:0]   id, id_n;
    logic [IW-1:0]   win;
    logic            found;
    logic [CW-1:0]   cnt, cnt_n;

    logic [31:0]     chk_data, chk_data_n;
    logic            chk_valid, chk_valid_n;
    logic [NREQ-1:0] gnt, gnt_n;
    logic            res_valid, res_valid_n;
    logic [2:0]      res_exc, res_exc_n;
    logic [IW-1:0]   res_id, res_id_n;
    logic            err, err_n;

    assign bus.CHK_DATA    = chk_data;
    assign bus.CHK_VALID   = chk_valid;
    assign bus.GNT         = gnt;
    assign bus.RES_VALID   = res_valid;
    assign bus.RES_EXC     = res_exc;
    assign bus.RES_ID      = res_id;
    assign bus.ERR_TIMEOUT = err;

    // Round-robin pick: first requesting index at or above ptr, wrapping.
    always_comb begin
        int j;
        logic [IW-1:0] jj;
        win   = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            jj = IW'(j);
            if (!found && bus.REQ[jj]) begin
                found = 1'b1;
                win   = jj;
            end
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        id_n        = id;
        cnt_n       = cnt;
        chk_data_n  = chk_data;
        chk_valid_n = chk_valid;
        gnt_n       = '0;
        res_valid_n = 1'b0;
        res_exc_n   = res_exc;
        res_id_n    = res_id;
        err_n       = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    chk_data_n  = bus.REQ_DATA[32*int'(win) +: 32];
                    id_n        = win;
                    chk_valid_n = 1'b1;
                    cnt_n       = '0;
                    state_n     = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.CHK_ACK || (TIMEOUT != 0 && cnt == TLAST)) begin
                    chk_valid_n = 1'b0;
                    res_valid_n = 1'b1;
                    res_exc_n   = bus.CHK_ACK ? bus.CHK_EXC : 3'b111;
                    err_n       = !bus.CHK_ACK;
                    res_id_n    = id;
                    gnt_n       = NREQ'(1) << id;
                    state_n     = RESP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RESP: begin
                ptr_n   = (id == IW'(NREQ - 1)) ? '0 : id + 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= IDLE;
            ptr       <= '0;
            id        <= '0;
            cnt       <= '0;
            chk_data  <= '0;
            chk_valid <= 1'b0;
            gnt       <= '0;
            res_valid <= 1'b0;
            res_exc   <= '0;
            res_id    <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            id        <= id_n;
            cnt       <= cnt_n;
            chk_data  <= chk_data_n;
            chk_valid <= chk_valid_n;
            gnt       <= gnt_n;
            res_valid <= res_valid_n;
            res_exc   <= res_exc_n;
            res_id    <= res_id_n;
            err       <= err_n;
        end
    end
endmodule

// File: tb/tb_exc_check_arbiter.sv
// Directed bench for exc_check_arbiter: vector table plus hand sequences
// for round-robin rotation, watchdog abort, mid-issue reset and REQ drop.
module tb_exc_check_arbiter;
    logic CLK;
    logic RSTN;
    logic ack_en;
    int   checks;
    int   errors;

    exc_check_arbiter_if #(.NREQ(3)) bus ();

    exc_check_arbiter #(.NREQ(3), .TIMEOUT(15)) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus.master)
    );

    function automatic logic [2:0] classify(input logic [31:0] w);
        if (w[30:23] == 8'hFF)
            return (w[22:0] == 23'd0) ? 3'b011 : 3'b100;
        return 3'b000;
    endfunction

    assign bus.CHK_ACK = ack_en & bus.CHK_VALID;
    assign bus.CHK_EXC = classify(bus.CHK_DATA);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  req;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [2:0]  gnt;
        logic [2:0]  exc;
        logic [1:0]  id;
        logic [31:0] word;
    } vec_t;

    vec_t vt [7];

    initial begin
        int ok;
        logic [31:0] aw [3];
        logic [2:0]  seq [4];
        logic [1:0]  sid [4];
        checks   = 0;
        errors   = 0;
        RSTN     = 1'b0;
        ack_en   = 1'b1;
        bus.REQ  = '0;
        bus.REQ_DATA = '0;

        // ptr walks 0 -> 1 -> 0 -> 1 -> 2 -> 0 -> 2 -> 1 across the table.
        vt[0] = '{3'b001, 32'h7F800000, 32'h0, 32'h0,
                  3'b001, 3'b011, 2'd0, 32'h7F800000};
        vt[1] = '{3'b100, 32'h0, 32'h0, 32'h7FC00000,
                  3'b100, 3'b100, 2'd2, 32'h7FC00000};
        vt[2] = '{3'b011, 32'h3F800000, 32'hFF800000, 32'h0,
                  3'b001, 3'b000, 2'd0, 32'h3F800000};
        vt[3] = '{3'b011, 32'h3F800000, 32'hFF800000, 32'h0,
                  3'b010, 3'b011, 2'd1, 32'hFF800000};
        vt[4] = '{3'b101, 32'h7F800001, 32'h0, 32'h00000000,
                  3'b100, 3'b000, 2'd2, 32'h00000000};
        vt[5] = '{3'b110, 32'h0, 32'hFFFFFFFF, 32'h7F800000,
                  3'b010, 3'b100, 2'd1, 32'hFFFFFFFF};
        vt[6] = '{3'b001, 32'h00000000, 32'h0, 32'h0,
                  3'b001, 3'b000, 2'd0, 32'h00000000};

        tick();
        tick();
        check("rst_chk_valid", 32'(bus.CHK_VALID), 32'd0);
        check("rst_chk_data", bus.CHK_DATA, 32'd0);
        check("rst_gnt", 32'(bus.GNT), 32'd0);
        check("rst_res", 32'({bus.RES_VALID, bus.RES_EXC, bus.RES_ID}), 32'd0);
        check("rst_err", 32'(bus.ERR_TIMEOUT), 32'd0);
        RSTN = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            bus.REQ_DATA = {vt[i].w2, vt[i].w1, vt[i].w0};
            bus.REQ      = vt[i].req;
            tick();
            check($sformatf("v%0d_chk_valid", i), 32'(bus.CHK_VALID), 32'd1);
            check($sformatf("v%0d_chk_data", i), bus.CHK_DATA, vt[i].word);
            check($sformatf("v%0d_early_res", i), 32'(bus.RES_VALID), 32'd0);
            tick();
            check($sformatf("v%0d_res_valid", i), 32'(bus.RES_VALID), 32'd1);
            check($sformatf("v%0d_gnt", i), 32'(bus.GNT), 32'(vt[i].gnt));
            check($sformatf("v%0d_exc", i), 32'(bus.RES_EXC), 32'(vt[i].exc));
            check($sformatf("v%0d_id", i), 32'(bus.RES_ID), 32'(vt[i].id));
            check($sformatf("v%0d_chk_drop", i), 32'(bus.CHK_VALID), 32'd0);
            bus.REQ = '0;
            tick();
            check($sformatf("v%0d_gnt_clr", i), 32'(bus.GNT), 32'd0);
            check($sformatf("v%0d_exc_hold", i), 32'(bus.RES_EXC), 32'(vt[i].exc));
        end

        // All three requesting from reset: rotation 0,1,2,0 every 3 cycles.
        RSTN = 1'b0;
        tick();
        RSTN = 1'b1;
        aw[0] = 32'h7FC00000;
        aw[1] = 32'hFF800000;
        aw[2] = 32'h7F800000;
        seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;
        sid[0] = 2'd0;   sid[1] = 2'd1;   sid[2] = 2'd2;   sid[3] = 2'd0;
        bus.REQ_DATA = {aw[2], aw[1], aw[0]};
        bus.REQ      = 3'b111;
        for (int g = 0; g < 4; g++) begin
            tick();
            check($sformatf("rr%0d_chk_data", g), bus.CHK_DATA, aw[sid[g]]);
            tick();
            check($sformatf("rr%0d_gnt", g), 32'(bus.GNT), 32'(seq[g]));
            check($sformatf("rr%0d_exc", g), 32'(bus.RES_EXC),
                  32'(classify(aw[sid[g]])));
            if (g == 3) bus.REQ = '0;
            tick();
            check($sformatf("rr%0d_gap", g), 32'(bus.GNT), 32'd0);
        end

        // Watchdog: checker never acknowledges, ptr is 1.
        ack_en  = 1'b0;
        bus.REQ = 3'b010;
        tick();
        check("to_chk_valid", 32'(bus.CHK_VALID), 32'd1);
        ok = 0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (bus.CHK_VALID && !bus.RES_VALID) ok++;
        end
        check("to_issue_cycles", 32'(ok), 32'd14);
        tick();
        check("to_res_valid", 32'(bus.RES_VALID), 32'd1);
        check("to_err", 32'(bus.ERR_TIMEOUT), 32'd1);
        check("to_exc", 32'(bus.RES_EXC), 32'h7);
        check("to_gnt", 32'(bus.GNT), 32'b010);
        check("to_id", 32'(bus.RES_ID), 32'd1);
        check("to_chk_drop", 32'(bus.CHK_VALID), 32'd0);
        bus.REQ = '0;
        tick();
        check("to_err_clr", 32'(bus.ERR_TIMEOUT), 32'd0);
        ack_en  = 1'b1;
        bus.REQ = 3'b111;
        tick();
        tick();
        check("to_ptr_next", 32'(bus.GNT), 32'b100);
        bus.REQ = '0;
        tick();

        // Reset while a request is in ISSUE; ptr was moved to 1 first.
        bus.REQ_DATA = {32'h0, 32'h0, 32'h7F800000};
        bus.REQ      = 3'b001;
        tick();
        tick();
        check("mr_pre_gnt", 32'(bus.GNT), 32'b001);
        bus.REQ = '0;
        tick();
        ack_en  = 1'b0;
        bus.REQ = 3'b100;
        tick();
        check("mr_issue", 32'(bus.CHK_VALID), 32'd1);
        #2 RSTN = 1'b0;
        #1;
        check("mr_chk_valid_async", 32'(bus.CHK_VALID), 32'd0);
        bus.REQ = '0;
        tick();
        tick();
        check("mr_no_result", 32'({bus.GNT, bus.RES_VALID}), 32'd0);
        RSTN   = 1'b1;
        ack_en = 1'b1;
        bus.REQ_DATA = {32'h0, 32'h7F800000, 32'h7FC00000};
        bus.REQ      = 3'b011;
        tick();
        check("mr_ptr0_data", bus.CHK_DATA, 32'h7FC00000);
        tick();
        check("mr_ptr0_gnt", 32'(bus.GNT), 32'b001);
        check("mr_ptr0_exc", 32'(bus.RES_EXC), 32'b100);
        bus.REQ = '0;
        tick();

        // Requester 0 drops REQ and its word right after selection.
        bus.REQ_DATA = {32'h0, 32'h0, 32'hFF800000};
        bus.REQ      = 3'b001;
        tick();
        bus.REQ      = '0;
        bus.REQ_DATA = '0;
        check("drop_latched", bus.CHK_DATA, 32'hFF800000);
        tick();
        check("drop_gnt", 32'(bus.GNT), 32'b001);
        check("drop_exc", 32'(bus.RES_EXC), 32'b011);
        ok = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (bus.GNT != 0 || bus.CHK_VALID) ok++;
        end
        check("drop_no_reserve", 32'(ok), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
